// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver on a 16x oversampling tick: synchronise rx, validate start, mid-bit sample, emit byte or framing error.
// Latency: valid/frame_err pulse one cycle after the stop-sample tick; no backpressure, the consumer must take each pulse.
module uart_rx_oversampled #(
    parameter int SAMPLE_RATE = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 tick_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err_out,
    output logic                 busy_out
);

    localparam int TW = $clog2(SAMPLE_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(SAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // Synchroniser resets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (tick_in) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    // A start bit that is high again at its midpoint was a glitch.
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = BRK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign frame_err_out = err_q;
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: frame-level model (queue of expected pulses plus last good byte) checked every cycle.
module tb_uart_rx_oversampled;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       tick_in;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_err_out;
    logic       busy_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_div = 1;
    int tick_ph = 0;
    int start_cyc = 0;
    int last_valid_cyc = -1;
    logic [7:0] model_data = 8'h00;
    logic [8:0] exp_q[$];   // {is_valid, byte}; is_valid=0 means framing error

    uart_rx_oversampled #(.SAMPLE_RATE(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .tick_in      (tick_in),
        .rx_in        (rx_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .frame_err_out(frame_err_out),
        .busy_out     (busy_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Sender: start, 8 data bits LSB first, stop; each bit held bit_ticks ticks.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ticks, input logic expect_pulse);
        int bc;
        bc = bit_ticks * tick_div;
        if (expect_pulse) exp_q.push_back({stop, b});
        rx_in = 1'b0;
        start_cyc = cyc;
        wait_cyc(bc);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            wait_cyc(bc);
        end
        rx_in = stop;
        wait_cyc(bc);
    endtask

    initial begin
        tick_in = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (tick_ph >= tick_div - 1) begin
                tick_ph = 0;
                tick_in = 1'b1;
            end else begin
                tick_ph++;
                tick_in = 1'b0;
            end
        end
    end

    // Compare process: every cycle against the frame-level model.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                check("rst_valid", valid_out, 0);
                check("rst_ferr", frame_err_out, 0);
                check("rst_data", data_out, 0);
                check("rst_busy", busy_out, 0);
                model_data = 8'h00;
            end else begin
                check("valid_ferr_exclusive", valid_out & frame_err_out, 0);
                if (valid_out || frame_err_out) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=0x%0h, want no pulse (cycle %0d)",
                                 valid_out, frame_err_out, data_out, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind_valid", valid_out, e[8]);
                        if (valid_out) begin
                            check("rx_byte", data_out, e[7:0]);
                            model_data = e[7:0];
                            last_valid_cyc = cyc;
                        end
                    end
                end
                check("data_hold", data_out, model_data);
            end
        end
    end

    initial begin
        rst_in = 1'b1;
        rx_in  = 1'b1;
        wait_cyc(3);
        check("reset_data", data_out, 8'h00);
        check("reset_valid", valid_out, 0);
        check("reset_busy", busy_out, 0);
        #2 rst_in = 1'b0;
        wait_cyc(5);

        // 0xA5 with a tick every cycle: 2 sync + 1 detect + 8 half bit + 9*16 = 155 cycles to the pulse.
        send_frame(8'hA5, 1'b1, 16, 1'b1);
        wait_cyc(20);
        check("a5_latency", last_valid_cyc - start_cyc, 155);
        check("a5_data", data_out, 8'hA5);
        check("a5_busy_after", busy_out, 0);
        check("a5_pending", exp_q.size(), 0);

        // Four-tick glitch: detected at edge 3, rejected at the evaluation edge 11.
        rx_in = 1'b0;
        wait_cyc(4);
        rx_in = 1'b1;
        wait_cyc(6);
        check("glitch_busy_before_eval", busy_out, 1);
        wait_cyc(1);
        check("glitch_idle_after_eval", busy_out, 0);
        wait_cyc(20);
        check("glitch_data", data_out, 8'hA5);
        check("glitch_pending", exp_q.size(), 0);

        // 0x3C with a low stop bit, line held low 40 more ticks: one error pulse, busy until line high.
        send_frame(8'h3C, 1'b0, 16, 1'b1);
        wait_cyc(40);
        rx_in = 1'b1;
        wait_cyc(2);
        check("break_busy_held", busy_out, 1);
        wait_cyc(1);
        check("break_busy_release", busy_out, 0);
        wait_cyc(20);
        check("break_data", data_out, 8'hA5);
        check("break_pending", exp_q.size(), 0);

        // Sender bit periods 15 and 17 ticks.
        send_frame(8'hC3, 1'b1, 15, 1'b1);
        wait_cyc(40);
        check("fast_sender_data", data_out, 8'hC3);
        send_frame(8'hC3, 1'b1, 17, 1'b1);
        wait_cyc(40);
        check("slow_sender_pending", exp_q.size(), 0);

        // Mid-clock reset during data bit 3 of an abandoned 0xF0; released while line is high.
        fork
            send_frame(8'hF0, 1'b1, 16, 1'b0);
            begin
                wait_cyc(76);
                check("abort_busy_before_rst", busy_out, 1);
                #2 rst_in = 1'b1;
                #1;
                check("abort_busy_in_rst", busy_out, 0);
                check("abort_data_in_rst", data_out, 8'h00);
                wait_cyc(12);
                #2 rst_in = 1'b0;
            end
        join
        wait_cyc(20);
        check("abort_no_busy", busy_out, 0);
        send_frame(8'h5A, 1'b1, 16, 1'b1);
        wait_cyc(20);
        check("after_abort_data", data_out, 8'h5A);
        check("after_abort_pending", exp_q.size(), 0);

        // Tick every 54 cycles, 0x00 and 0xFF back-to-back with a one-bit stop.
        tick_div = 54;
        wait_cyc(60);
        send_frame(8'h00, 1'b1, 16, 1'b1);
        send_frame(8'hFF, 1'b1, 16, 1'b1);
        wait_cyc(2000);
        check("b2b_data", data_out, 8'hFF);
        check("b2b_pending", exp_q.size(), 0);
        check("b2b_busy", busy_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
